// File: rtl/zap_wb_arbiter_if.sv
// Signal bundle for the two-master Wishbone arbiter: code and data master ports,
// the shared adapter-side port, and the read-data/ACK return paths.
interface zap_wb_arbiter_if;
    // Code (instruction) master
    logic        i_c_wb_cyc;
    logic        i_c_wb_stb;
    logic        i_c_wb_we;
    logic [3:0]  i_c_wb_sel;
    logic [2:0]  i_c_wb_cti;
    logic [31:0] i_c_wb_adr;
    logic [31:0] i_c_wb_dat;
    logic        o_c_wb_ack;
    logic [31:0] o_c_wb_dat;

    // Data master
    logic        i_d_wb_cyc;
    logic        i_d_wb_stb;
    logic        i_d_wb_we;
    logic [3:0]  i_d_wb_sel;
    logic [2:0]  i_d_wb_cti;
    logic [31:0] i_d_wb_adr;
    logic [31:0] i_d_wb_dat;
    logic        o_d_wb_ack;
    logic [31:0] o_d_wb_dat;

    // Shared port towards the store-FIFO/bus adapter
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [3:0]  o_wb_sel;
    logic [2:0]  o_wb_cti;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic        i_wb_ack;
    logic [31:0] i_wb_dat;

    // Arbiter side
    modport slave (
        input  i_c_wb_cyc, i_c_wb_stb, i_c_wb_we, i_c_wb_sel, i_c_wb_cti, i_c_wb_adr, i_c_wb_dat,
        output o_c_wb_ack, o_c_wb_dat,
        input  i_d_wb_cyc, i_d_wb_stb, i_d_wb_we, i_d_wb_sel, i_d_wb_cti, i_d_wb_adr, i_d_wb_dat,
        output o_d_wb_ack, o_d_wb_dat,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_cti, o_wb_adr, o_wb_dat,
        input  i_wb_ack, i_wb_dat
    );

    // Environment side: caches driving requests, adapter answering them
    modport master (
        output i_c_wb_cyc, i_c_wb_stb, i_c_wb_we, i_c_wb_sel, i_c_wb_cti, i_c_wb_adr, i_c_wb_dat,
        input  o_c_wb_ack, o_c_wb_dat,
        output i_d_wb_cyc, i_d_wb_stb, i_d_wb_we, i_d_wb_sel, i_d_wb_cti, i_d_wb_adr, i_d_wb_dat,
        input  o_d_wb_ack, o_d_wb_dat,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_cti, o_wb_adr, o_wb_dat,
        output i_wb_ack, i_wb_dat
    );
endinterface

// File: rtl/zap_wb_arbiter.sv
// Two-master Wishbone arbiter: grants the adapter port to code or data for a whole
// Wishbone cycle (bursts included) and routes ACK back only to the current owner.
module zap_wb_arbiter #(
    parameter bit FIXED_DATA_PRI = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    zap_wb_arbiter_if.slave    bus,
    output logic [1:0]         o_gnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_C = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_owner_q, last_owner_d;   // 0 = code, 1 = data

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Grant decisions are only taken from IDLE, so the bus is never preempted
    // and every handover passes through one dead cycle.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (bus.i_c_wb_cyc && bus.i_d_wb_cyc) begin
                    state_d = (FIXED_DATA_PRI || !last_owner_q) ? GNT_D : GNT_C;
                end else if (bus.i_d_wb_cyc) begin
                    state_d = GNT_D;
                end else if (bus.i_c_wb_cyc) begin
                    state_d = GNT_C;
                end
            end
            GNT_C: begin
                if (!bus.i_c_wb_cyc) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b0;
                end
            end
            GNT_D: begin
                if (!bus.i_d_wb_cyc) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_gnt          = 2'b00;
        bus.o_wb_cyc   = 1'b0;
        bus.o_wb_stb   = 1'b0;
        bus.o_wb_we    = 1'b0;
        bus.o_wb_sel   = 4'd0;
        bus.o_wb_cti   = 3'd0;
        bus.o_wb_adr   = 32'd0;
        bus.o_wb_dat   = 32'd0;
        bus.o_c_wb_ack = 1'b0;
        bus.o_d_wb_ack = 1'b0;
        case (state_q)
            GNT_C: begin
                o_gnt          = 2'b01;
                bus.o_wb_cyc   = bus.i_c_wb_cyc;
                bus.o_wb_stb   = bus.i_c_wb_stb;
                bus.o_wb_we    = bus.i_c_wb_we;
                bus.o_wb_sel   = bus.i_c_wb_sel;
                bus.o_wb_cti   = bus.i_c_wb_cti;
                bus.o_wb_adr   = bus.i_c_wb_adr;
                bus.o_wb_dat   = bus.i_c_wb_dat;
                bus.o_c_wb_ack = bus.i_wb_ack;
            end
            GNT_D: begin
                o_gnt          = 2'b10;
                bus.o_wb_cyc   = bus.i_d_wb_cyc;
                bus.o_wb_stb   = bus.i_d_wb_stb;
                bus.o_wb_we    = bus.i_d_wb_we;
                bus.o_wb_sel   = bus.i_d_wb_sel;
                bus.o_wb_cti   = bus.i_d_wb_cti;
                bus.o_wb_adr   = bus.i_d_wb_adr;
                bus.o_wb_dat   = bus.i_d_wb_dat;
                bus.o_d_wb_ack = bus.i_wb_ack;
            end
            default: ;
        endcase
    end

    // Read data is shared; each master qualifies it with its own ACK.
    assign bus.o_c_wb_dat = bus.i_wb_dat;
    assign bus.o_d_wb_dat = bus.i_wb_dat;

    // An ACK with no owner can only come from a misbehaving adapter.
    a_no_ack_in_idle: assert property (@(posedge i_clk) disable iff (i_reset)
        !(state_q == IDLE && bus.i_wb_ack));

endmodule
